// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
//
// Pipeline register and writeback selector between the data-memory stage and
// the register file. An instruction is taken from the memory stage only on
// cycles where memory is not stalling. Every stall cycle becomes a bubble in
// the WB slot. The block picks the writeback value (ALU result, load data or
// link address) and counts retired instructions. It also freezes the core on
// HALT or on a memory error, and requests a single memory dump when that
// happens.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   in_valid      memory-stage slot holds a real instruction
//   in_regWrite   instruction writes a register
//   in_memToReg   writeback value is load data
//   in_link       writeback value is PC+2; has priority over in_memToReg
//   in_writeReg   destination register index
//   in_aluResult  execute result
//   in_pcPlus2    link address
//   in_halt       instruction is HALT
//   memReadData   load data, meaningful when memStall=0
//   memStall      memory access still in progress
//   memErr        memory-stage error flag
//   wb_valid      WB slot holds a retired instruction
//   wb_regWrite   register-file write enable
//   wb_writeReg   register-file write index
//   wb_data       register-file write data and forwarding value
//   dump          one-cycle pulse when HALT or an error retires
//   halted        sticky, core frozen
//   err           sticky memory error
//   retired       retired-instruction count, wraps at 16 bits
// ---------------------------------------------------------------------------
module mem_wb_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        in_regWrite,
    input  logic        in_memToReg,
    input  logic        in_link,
    input  logic [2:0]  in_writeReg,
    input  logic [15:0] in_aluResult,
    input  logic [15:0] in_pcPlus2,
    input  logic        in_halt,
    input  logic [15:0] memReadData,
    input  logic        memStall,
    input  logic        memErr,
    output logic        wb_valid,
    output logic        wb_regWrite,
    output logic [2:0]  wb_writeReg,
    output logic [15:0] wb_data,
    output logic        dump,
    output logic        halted,
    output logic        err,
    output logic [15:0] retired
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic        capture;     // WB register takes the memory-stage slot
    logic        accept;      // a real instruction retires this cycle
    logic        stop;        // the retiring instruction freezes the core
    logic [15:0] sel_data_p0;

    // The link address has priority over load data.
    function automatic logic [15:0] wb_select(
        input logic        link,
        input logic        mem_to_reg,
        input logic [15:0] alu,
        input logic [15:0] mem,
        input logic [15:0] pc
    );
        if (link)
            return pc;
        else if (mem_to_reg)
            return mem;
        else
            return alu;
    endfunction

    assign sel_data_p0 = wb_select(in_link, in_memToReg, in_aluResult,
                                   memReadData, in_pcPlus2);

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        accept    = 1'b0;
        stop      = 1'b0;
        if (state == RUN) begin
            capture = ~memStall;
            accept  = capture & in_valid;
            stop    = accept & (in_halt | memErr);
            if (stop)
                state_nxt = HALTED;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= RUN;
        else
            state <= state_nxt;
    end

    // The halted output is the FSM state itself, so it sets on the same edge
    // that the halting instruction appears in the WB slot.
    assign halted = (state == HALTED);

    // ---- MEM -> WB register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid    <= 1'b0;
            wb_regWrite <= 1'b0;
            wb_writeReg <= 3'd0;
            wb_data     <= 16'd0;
            dump        <= 1'b0;
            err         <= 1'b0;
            retired     <= 16'd0;
        end else begin
            // Bubbles clear only the control bits; index and data hold so the
            // forwarding value stays stable across stalls.
            wb_valid    <= accept;
            wb_regWrite <= accept & in_regWrite & ~in_halt & ~memErr;
            dump        <= stop;
            if (capture) begin
                wb_writeReg <= in_writeReg;
                wb_data     <= sel_data_p0;
            end
            if (accept & memErr)
                err <= 1'b1;
            if (accept)
                retired <= retired + 16'd1;
        end
    end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Pipeline register and writeback selector between the data-memory stage and the register file. It accepts the instruction leaving the memory stage only when the cache-backed memory is not stalling, and inserts a bubble on every stall cycle. It selects the writeback value (ALU result, load data, or link address) and counts retired instructions. It latches halt/error so the core freezes cleanly and triggers the memory dump exactly once.

## Interface
- No parameters; data width fixed at 16 bits, register index at 3 bits.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  memory-stage slot holds a real instruction.
- in_regWrite  in  1  instruction writes a register.
- in_memToReg  in  1  writeback value is load data.
- in_link  in  1  writeback value is PC+2 (JAL/JALR); overrides in_memToReg.
- in_writeReg  in  3  destination register.
- in_aluResult  in  16  execute result.
- in_pcPlus2  in  16  link address.
- in_halt  in  1  instruction is HALT.
- memReadData  in  16  data from memory stage; valid in the cycle memStall=0.
- memStall  in  1  memory stage stall (access in progress).
- memErr  in  1  memory stage error flag.
- wb_valid  out  1  registered: WB slot holds a retired instruction.
- wb_regWrite  out  1  register-file write enable.
- wb_writeReg  out  3  register-file write index.
- wb_data  out  16  register-file write data; also the forwarding value.
- dump  out  1  one-cycle pulse when HALT or error retires.
- halted  out  1  sticky; core frozen.
- err  out  1  sticky memory error.
- retired  out  16  retired-instruction count.

## Operation
- States: RUN, HALTED. Reset enters RUN.
- Capture condition in RUN: capture = ~memStall. On capture, the WB register loads in_valid, in_writeReg, selected data, and the flags below.
- When memStall=1, or in HALTED, the WB register loads a bubble: wb_valid=0 and wb_regWrite=0. wb_writeReg and wb_data hold their previous values.
- Data select: in_link ? in_pcPlus2 : in_memToReg ? memReadData : in_aluResult.
- wb_regWrite = capture & in_valid & in_regWrite & ~in_halt & ~memErr.
- retired increments by 1 on every capture with in_valid=1 and wraps 0xFFFF->0x0000. A HALT instruction counts. An invalid slot does not count.
- HALT retire (capture & in_valid & in_halt): the state moves RUN->HALTED, dump pulses high for the next cycle only, and halted is set.
- Error retire (capture & in_valid & memErr): err is set and the block behaves the same as HALT retire. When HALT and memErr coincide, one dump pulse is produced.
- HALTED is left only by reset. In HALTED, in_* are ignored, retired is frozen, and dump stays 0.

## Timing
- All outputs are registered, with 1-cycle latency from the capture edge to the wb_* outputs.
- Reset values: wb_valid=0, wb_regWrite=0, wb_writeReg=0, wb_data=0, dump=0, halted=0, err=0, retired=0.
- A load that stalls N cycles produces N bubble cycles on wb_*. The load's data appears on the edge after memStall falls.
- Asserting rst_n low mid-stall or mid-HALTED clears all outputs immediately, asynchronously. The first capture is possible on the first rising edge after rst_n rises.
- memStall=1 together with in_halt=1 does not halt: the HALT is captured only when memStall=0.
- The dump pulse is aligned with the cycle where wb_valid=1 for the halting instruction.

## Test plan
- ALU op: in_valid=1, in_regWrite=1, writeReg=3, aluResult=0x1234, memStall=0 -> next cycle wb_valid=1, wb_regWrite=1, wb_writeReg=3, wb_data=0x1234, retired=1.
- Stalled load: in_memToReg=1 with memStall=1 for 3 cycles, then memStall=0 with memReadData=0xBEEF -> 3 bubble cycles (wb_regWrite=0), then wb_data=0xBEEF with wb_regWrite=1, and retired increments once.
- Link priority: in_link=1, in_memToReg=1, pcPlus2=0x0042 -> wb_data=0x0042.
- HALT: valid HALT with memStall=0 -> dump=1 for exactly one cycle, halted=1, wb_regWrite=0. Subsequent valid ALU inputs leave wb_valid=0 and retired unchanged.
- Error: valid load with memErr=1 -> err=1, halted=1, one dump pulse, wb_regWrite=0.
- Wrap/reset: preload retired to 0xFFFF via 65535 retires, retire one more -> 0x0000. Asserting rst_n low while memStall=1 clears all outputs immediately.
